// File: rtl/dmem_pipe2.sv
// M1/M2 data-memory responder: stores commit at the M1->M2 edge, loads read
// synchronously at that edge and are aligned/extended combinationally in M2.
module dmem_pipe2 #(
   parameter int ADDR_WIDTH = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_m,
   input  logic        mem_read_m1,
   input  logic        mem_write_m1,
   input  logic [2:0]  funct3_m1,
   input  logic [31:0] addr_m1,
   input  logic [31:0] write_data_m1,
   output logic [31:0] read_data_m2,
   output logic        load_valid_m2,
   output logic        misaligned_m2
);

   localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

   logic [31:0] mem_q [DEPTH];

   logic [31:0] word_q;
   logic [2:0]  funct3_q;
   logic [1:0]  off_q;
   logic        ld_q;
   logic        mis_q;

   logic [ADDR_WIDTH-3:0] idx_d;
   logic        st_req_d, ld_req_d, st_ok_d, ld_ok_d, mis_d, we_d;
   logic [3:0]  be_d;
   logic [31:0] wdata_d;
   logic        unused_addr;

   function automatic logic legal_load(input logic [2:0] f3);
      return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
             (f3 == 3'b100) || (f3 == 3'b101);
   endfunction

   function automatic logic legal_store(input logic [2:0] f3);
      return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
   endfunction

   function automatic logic aligned(input logic [2:0] f3, input logic [1:0] a);
      case (f3[1:0])
         2'b01:   return a[0] == 1'b0;
         2'b10:   return a == 2'b00;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      b = w[{off, 3'b000} +: 8];
      h = off[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  return 32'(b);
         3'b100:  return {24'h0, b};
         3'b001:  return 32'(h);
         3'b101:  return {16'h0, h};
         3'b010:  return w;
         default: return 32'h0;
      endcase
   endfunction

   assign unused_addr = ^addr_m1[31:ADDR_WIDTH];
   assign idx_d       = addr_m1[ADDR_WIDTH-1:2];

   // A simultaneous read+write request is a store only.
   always_comb begin
      st_req_d = mem_write_m1;
      ld_req_d = mem_read_m1 & ~mem_write_m1;
      st_ok_d  = st_req_d & legal_store(funct3_m1) & aligned(funct3_m1, addr_m1[1:0]);
      ld_ok_d  = ld_req_d & legal_load(funct3_m1) & aligned(funct3_m1, addr_m1[1:0]);
      mis_d    = (st_req_d & ~st_ok_d) | (ld_req_d & ~ld_ok_d);
      we_d     = st_ok_d & ~stall_m & ~rst;
      case (funct3_m1[1:0])
         2'b00: begin
            be_d    = 4'b0001 << addr_m1[1:0];
            wdata_d = {4{write_data_m1[7:0]}};
         end
         2'b01: begin
            be_d    = addr_m1[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{write_data_m1[15:0]}};
         end
         default: begin
            be_d    = 4'b1111;
            wdata_d = write_data_m1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (we_d) begin
         for (int i = 0; i < 4; i++) begin
            if (be_d[i]) mem_q[idx_d][8*i +: 8] <= wdata_d[8*i +: 8];
         end
      end
   end

   // ---- M1 -> M2 boundary ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_q   <= 32'h0;
         funct3_q <= 3'b000;
         off_q    <= 2'b00;
         ld_q     <= 1'b0;
         mis_q    <= 1'b0;
      end else if (!stall_m) begin
         funct3_q <= funct3_m1;
         off_q    <= addr_m1[1:0];
         ld_q     <= ld_ok_d;
         mis_q    <= mis_d;
         if (ld_req_d) word_q <= mem_q[idx_d];
      end
   end

   assign read_data_m2  = ld_q ? extract(word_q, funct3_q, off_q) : 32'h0;
   assign load_valid_m2 = ld_q;
   assign misaligned_m2 = mis_q;

endmodule

// File: tb/tb_dmem_pipe2.sv
// Bench for dmem_pipe2: directed vector table, stall/reset sequences and
// random traffic compared against a byte-addressed reference memory.
module tb_dmem_pipe2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_m = 1'b0;
   logic        mem_read_m1 = 1'b0;
   logic        mem_write_m1 = 1'b0;
   logic [2:0]  funct3_m1 = 3'b000;
   logic [31:0] addr_m1 = 32'h0;
   logic [31:0] write_data_m1 = 32'h0;
   logic [31:0] read_data_m2;
   logic        load_valid_m2;
   logic        misaligned_m2;

   dmem_pipe2 #(.ADDR_WIDTH(12)) dut (
      .clk(clk), .rst(rst), .stall_m(stall_m),
      .mem_read_m1(mem_read_m1), .mem_write_m1(mem_write_m1),
      .funct3_m1(funct3_m1), .addr_m1(addr_m1), .write_data_m1(write_data_m1),
      .read_data_m2(read_data_m2), .load_valid_m2(load_valid_m2),
      .misaligned_m2(misaligned_m2)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;
   byte unsigned mb [4096];

   typedef struct {
      logic        wr;
      logic        rd;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] ed;
      logic        ev;
      logic        em;
   } vec_t;

   vec_t tbl [22];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_out(input string name, input logic [31:0] ed, input logic ev,
                            input logic em);
      check({name, ".data"}, read_data_m2, ed);
      check({name, ".valid"}, {31'h0, load_valid_m2}, {31'h0, ev});
      check({name, ".mis"}, {31'h0, misaligned_m2}, {31'h0, em});
   endtask

   // Reference: byte-addressed memory of 2^12 bytes, sizes 1/2/4, natural alignment.
   task automatic model(input logic wr, input logic rd, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] ed, output logic ev, output logic em);
      int a, size;
      longint v;
      a = int'(addr % 4096);
      size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      ed = 32'h0; ev = 1'b0; em = 1'b0;
      if (wr) begin
         if (f3 > 3'd2 || (a % size) != 0) em = 1'b1;
         else for (int i = 0; i < size; i++) mb[a + i] = wd[8*i +: 8];
      end else if (rd) begin
         if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (a % size) != 0) em = 1'b1;
         else begin
            v = 0;
            for (int i = 0; i < size; i++) v = v | (longint'(mb[a + i]) << (8 * i));
            if (!f3[2] && v[8*size-1]) v = v - (longint'(1) << (8 * size));
            ed = v[31:0];
            ev = 1'b1;
         end
      end
   endtask

   task automatic req(input logic wr, input logic rd, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] ed, output logic ev, output logic em);
      mem_write_m1 = wr; mem_read_m1 = rd; funct3_m1 = f3;
      addr_m1 = addr; write_data_m1 = wd;
      model(wr, rd, f3, addr, wd, ed, ev, em);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] ed;
      logic        ev, em;

      tbl = '{
         '{1'b1, 1'b0, 3'd2, 32'h010, 32'h8000_00F1, 32'h0,         1'b0, 1'b0},
         '{1'b0, 1'b1, 3'd0, 32'h010, 32'h0,         32'hFFFF_FFF1, 1'b1, 1'b0},
         '{1'b0, 1'b1, 3'd4, 32'h010, 32'h0,         32'h0000_00F1, 1'b1, 1'b0},
         '{1'b0, 1'b1, 3'd1, 32'h010, 32'h0,         32'h0000_00F1, 1'b1, 1'b0},
         '{1'b0, 1'b1, 3'd5, 32'h010, 32'h0,         32'h0000_00F1, 1'b1, 1'b0},
         '{1'b0, 1'b1, 3'd2, 32'h010, 32'h0,         32'h8000_00F1, 1'b1, 1'b0},
         '{1'b1, 1'b0, 3'd2, 32'h010, 32'h1122_3344, 32'h0,         1'b0, 1'b0},
         '{1'b1, 1'b0, 3'd0, 32'h013, 32'h0000_00AB, 32'h0,         1'b0, 1'b0},
         '{1'b0, 1'b1, 3'd2, 32'h010, 32'h0,         32'hAB22_3344, 1'b1, 1'b0},
         '{1'b1, 1'b0, 3'd1, 32'h012, 32'h0000_BEEF, 32'h0,         1'b0, 1'b0},
         '{1'b0, 1'b1, 3'd2, 32'h010, 32'h0,         32'hBEEF_3344, 1'b1, 1'b0},
         '{1'b1, 1'b0, 3'd2, 32'h012, 32'hDEAD_BEEF, 32'h0,         1'b0, 1'b1},
         '{1'b0, 1'b1, 3'd2, 32'h010, 32'h0,         32'hBEEF_3344, 1'b1, 1'b0},
         '{1'b0, 1'b1, 3'd1, 32'h011, 32'h0,         32'h0,         1'b0, 1'b1},
         '{1'b1, 1'b0, 3'd2, 32'h1010, 32'h5,        32'h0,         1'b0, 1'b0},
         '{1'b0, 1'b1, 3'd2, 32'h010, 32'h0,         32'h0000_0005, 1'b1, 1'b0},
         '{1'b1, 1'b1, 3'd2, 32'h020, 32'h77,        32'h0,         1'b0, 1'b0},
         '{1'b0, 1'b1, 3'd2, 32'h020, 32'h0,         32'h0000_0077, 1'b1, 1'b0},
         '{1'b0, 1'b1, 3'd3, 32'h020, 32'h0,         32'h0,         1'b0, 1'b1},
         '{1'b1, 1'b0, 3'd4, 32'h020, 32'hFFFF_FFFF, 32'h0,         1'b0, 1'b1},
         '{1'b0, 1'b1, 3'd2, 32'h020, 32'h0,         32'h0000_0077, 1'b1, 1'b0},
         '{1'b0, 1'b0, 3'd2, 32'h020, 32'h0,         32'h0,         1'b0, 1'b0}
      };

      #12;
      check_out("reset", 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      for (int w = 0; w < 1024; w++) req(1'b1, 1'b0, 3'd2, w * 4, 32'h0, ed, ev, em);

      foreach (tbl[i]) begin
         req(tbl[i].wr, tbl[i].rd, tbl[i].f3, tbl[i].addr, tbl[i].wd, ed, ev, em);
         check_out($sformatf("vec%0d", i), tbl[i].ed, tbl[i].ev, tbl[i].em);
      end

      // Stall: outputs frozen, stalled store must not reach RAM.
      req(1'b0, 1'b1, 3'd2, 32'h010, 32'h0, ed, ev, em);
      check_out("stall_pre", 32'h5, 1'b1, 1'b0);
      stall_m = 1'b1;
      for (int c = 0; c < 3; c++) begin
         mem_write_m1 = 1'b1; mem_read_m1 = c[0]; funct3_m1 = c[2:0];
         addr_m1 = 32'h010; write_data_m1 = 32'hFFFF_FFFF - c;
         @(posedge clk);
         #1;
         check_out($sformatf("stall%0d", c), 32'h5, 1'b1, 1'b0);
      end
      stall_m = 1'b0;
      req(1'b0, 1'b1, 3'd0, 32'h010, 32'h0, ed, ev, em);
      check_out("stall_post", 32'h5, 1'b1, 1'b0);

      // Asynchronous reset mid-cycle, with a store held across an edge.
      #2;
      rst = 1'b1;
      mem_write_m1 = 1'b1; mem_read_m1 = 1'b0; funct3_m1 = 3'd2;
      addr_m1 = 32'h010; write_data_m1 = 32'hAAAA_AAAA;
      #1;
      check_out("async_rst", 32'h0, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      req(1'b0, 1'b1, 3'd2, 32'h010, 32'h0, ed, ev, em);
      check_out("rst_nowrite", 32'h5, 1'b1, 1'b0);

      for (int n = 0; n < 400; n++) begin
         logic        wr, rd;
         logic [2:0]  f3;
         logic [31:0] addr, wd;
         wr = 1'($urandom_range(0, 1));
         rd = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         addr = $urandom & 32'hFFFF_F03F;
         wd = $urandom;
         req(wr, rd, f3, addr, wd, ed, ev, em);
         check_out($sformatf("rnd%0d", n), ed, ev, em);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
